// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps one shared ALU and one unified memory port
// through fetch/decode/execute/memory/writeback and drives the datapath controls.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       instr_done,
    output logic       halted,
    output logic       bus_err,
    output logic [3:0] state_o
);

    localparam logic [3:0] S_START  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC   = 4'd3;
    localparam logic [3:0] S_WB_ALU = 4'd4;
    localparam logic [3:0] S_ADDR   = 4'd5;
    localparam logic [3:0] S_MEM_RD = 4'd6;
    localparam logic [3:0] S_WB_MEM = 4'd7;
    localparam logic [3:0] S_MEM_WR = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JAL    = 4'd10;
    localparam logic [3:0] S_JALR   = 4'd11;
    localparam logic [3:0] S_HALT   = 4'd12;
    localparam logic [3:0] S_ERR    = 4'd13;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // The counter only has to hold MEM_TIMEOUT-1; the final wait cycle is
    // detected before it would increment to MEM_TIMEOUT.
    localparam int              CNT_W       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam int              LAST_WAIT   = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
    localparam logic [CNT_W-1:0] LAST_WAIT_C = CNT_W'(LAST_WAIT);
    localparam bit              TO_EN       = (MEM_TIMEOUT != 0);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_wait;
    logic             timeout_hit;

    assign mem_wait    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout_hit = TO_EN && mem_wait && !mem_ready && (wait_cnt_q == LAST_WAIT_C);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START:  state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_I, OP_LUI, OP_AUIPC: state_d = S_EXEC;
                    OP_LOAD, OP_STORE:            state_d = S_ADDR;
                    OP_BRANCH:                    state_d = S_BRANCH;
                    OP_JAL:                       state_d = S_JAL;
                    OP_JALR:                      state_d = S_JALR;
                    default:                      state_d = S_HALT;
                endcase
            end
            S_EXEC:   state_d = S_WB_ALU;
            S_WB_ALU: state_d = S_FETCH;
            S_ADDR:   state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
            S_WB_MEM: state_d = S_FETCH;
            S_MEM_WR: if (mem_ready) state_d = S_FETCH;
            S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_ERR;
        endcase
        if (timeout_hit) state_d = S_ERR;
    end

    always_comb begin
        wait_cnt_d = '0;
        if (mem_wait && !mem_ready && (state_d == state_q)) wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_START;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        instr_done = 1'b0;
        halted     = 1'b0;
        bus_err    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                // Branch/JAL target computed here from old_pc + imm into ALUOut.
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            S_EXEC: begin
                case (opcode)
                    OP_R:     begin alu_src_a = 2'b01; alu_src_b = 2'b00; alu_op = 2'b10; end
                    OP_I:     begin alu_src_a = 2'b01; alu_src_b = 2'b10; alu_op = 2'b11; end
                    OP_LUI:   begin alu_src_a = 2'b11; alu_src_b = 2'b10; end
                    OP_AUIPC: begin alu_src_a = 2'b10; alu_src_b = 2'b10; end
                    default:  ;
                endcase
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                wb_sel     = 2'b01;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b01;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_en      = zero;
                instr_done = 1'b1;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                wb_sel     = 2'b10;
                pc_en      = 1'b1;
                pc_src     = 2'b01;
                instr_done = 1'b1;
            end
            S_JALR: begin
                // rd takes the pre-update PC (already PC+4) while PC loads the target.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                reg_write  = 1'b1;
                wb_sel     = 2'b10;
                instr_done = 1'b1;
            end
            S_HALT: halted = 1'b1;
            S_ERR: begin
                halted  = 1'b1;
                bus_err = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level reference model producing the
// expected per-cycle state/control trace, table vectors, and corner sequences.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, iord, ir_write, pc_en, reg_write;
    logic       instr_done, halted, bus_err;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
    logic [3:0] state_o;
    logic [22:0] obs;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .instr_done(instr_done),
        .halted(halted), .bus_err(bus_err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs = {state_o, mem_read, mem_write, iord, ir_write, pc_en, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, instr_done, halted, bus_err};

    localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                       7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                                       7'b1100111};

    typedef struct {
        logic [3:0] st;
        logic       rdy;
    } step_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        int         fw;
        int         mw;
        logic       z;
        int         cyc;
        int         rw;
        int         pce;
        int         done;
    } vec_t;

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Control outputs each state must show, straight from the state's output list.
    function automatic logic [22:0] exp_out(input logic [3:0] st, input logic [6:0] op,
                                            input logic rdy, input logic z);
        logic mr = 0, mw = 0, io = 0, irw = 0, pce = 0, rw = 0, dn = 0, hl = 0, be = 0;
        logic [1:0] pcs = 0, sa = 0, sb = 0, aop = 0, wbs = 0;
        case (st)
            4'd1: begin mr = 1; sb = 2'b01; irw = rdy; pce = rdy; end
            4'd2: begin sa = 2'b10; sb = 2'b10; end
            4'd3: begin
                if (op == 7'b0110011) begin sa = 2'b01; sb = 2'b00; aop = 2'b10; end
                if (op == 7'b0010011) begin sa = 2'b01; sb = 2'b10; aop = 2'b11; end
                if (op == 7'b0110111) begin sa = 2'b11; sb = 2'b10; end
                if (op == 7'b0010111) begin sa = 2'b10; sb = 2'b10; end
            end
            4'd4: begin rw = 1; dn = 1; end
            4'd5: begin sa = 2'b01; sb = 2'b10; end
            4'd6: begin mr = 1; io = 1; end
            4'd7: begin rw = 1; wbs = 2'b01; dn = 1; end
            4'd8: begin mw = 1; io = 1; dn = rdy; end
            4'd9: begin sa = 2'b01; aop = 2'b01; pcs = 2'b01; pce = z; dn = 1; end
            4'd10: begin rw = 1; wbs = 2'b10; pce = 1; pcs = 2'b01; dn = 1; end
            4'd11: begin sa = 2'b01; sb = 2'b10; pcs = 2'b10; pce = 1; rw = 1; wbs = 2'b10; dn = 1; end
            4'd12: hl = 1;
            4'd13: begin hl = 1; be = 1; end
            default: ;
        endcase
        return {st, mr, mw, io, irw, pce, pcs, sa, sb, aop, rw, wbs, dn, hl, be};
    endfunction

    // Entered just after a rising edge; drives inputs, checks on the falling edge.
    task automatic run_cycle(input logic rdy, input logic z, input logic [6:0] op,
                             input logic [3:0] st, input string name,
                             output logic o_done, output logic o_rw, output logic o_pce);
        mem_ready = rdy;
        zero      = z;
        opcode    = op;
        @(negedge clk);
        check(name, obs, exp_out(st, op, rdy, z));
        o_done = instr_done;
        o_rw   = reg_write;
        o_pce  = pc_en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        zero = 1'b0;
        opcode = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hold", obs, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", obs, '0);
        @(posedge clk);
        #1;
    endtask

    // Builds the expected state trace of one instruction from its class and the
    // planned wait counts, then plays it against the DUT.
    task automatic run_instr(input string name, input logic [6:0] op, input int fw, input int mw,
                             input logic z, output int cyc, output int rw, output int pce,
                             output int done);
        step_t q[$];
        logic d, r, p;
        for (int i = 0; i <= fw; i++) q.push_back('{4'd1, (i == fw)});
        q.push_back('{4'd2, 1'($urandom)});
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
                q.push_back('{4'd3, 1'($urandom)});
                q.push_back('{4'd4, 1'($urandom)});
            end
            7'b0000011: begin
                q.push_back('{4'd5, 1'($urandom)});
                for (int i = 0; i <= mw; i++) q.push_back('{4'd6, (i == mw)});
                q.push_back('{4'd7, 1'($urandom)});
            end
            7'b0100011: begin
                q.push_back('{4'd5, 1'($urandom)});
                for (int i = 0; i <= mw; i++) q.push_back('{4'd8, (i == mw)});
            end
            7'b1100011: q.push_back('{4'd9, 1'($urandom)});
            7'b1101111: q.push_back('{4'd10, 1'($urandom)});
            7'b1100111: q.push_back('{4'd11, 1'($urandom)});
            default: for (int i = 0; i < 5; i++) q.push_back('{4'd12, 1'($urandom)});
        endcase
        cyc = 0; rw = 0; pce = 0; done = 0;
        for (int i = 0; i < q.size(); i++) begin
            run_cycle(q[i].rdy, (q[i].st == 4'd9) ? z : 1'($urandom),
                      (q[i].st == 4'd1) ? 7'($urandom) : op, q[i].st,
                      $sformatf("%s st%0d step%0d", name, q[i].st, i), d, r, p);
            if (d && done == 0) cyc = i + 1;
            done += int'(d);
            rw   += int'(r);
            pce  += int'(p);
        end
        $display("instr %s op=%b fw=%0d mw=%0d z=%0b cycles=%0d", name, op, fw, mw, z, cyc);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        int cyc, rw, pce, done;
        logic d, r, p;

        vecs[0]  = '{"rtype",      7'b0110011, 0, 0,  1'b0, 4,  1, 1, 1};
        vecs[1]  = '{"itype_fw1",  7'b0010011, 1, 0,  1'b0, 5,  1, 1, 1};
        vecs[2]  = '{"lui",        7'b0110111, 0, 0,  1'b0, 4,  1, 1, 1};
        vecs[3]  = '{"auipc_fw2",  7'b0010111, 2, 0,  1'b0, 6,  1, 1, 1};
        vecs[4]  = '{"load_mw3",   7'b0000011, 0, 3,  1'b0, 8,  1, 1, 1};
        vecs[5]  = '{"store",      7'b0100011, 0, 0,  1'b0, 4,  0, 1, 1};
        vecs[6]  = '{"store_w",    7'b0100011, 1, 2,  1'b0, 7,  0, 1, 1};
        vecs[7]  = '{"branch_t",   7'b1100011, 0, 0,  1'b1, 3,  0, 2, 1};
        vecs[8]  = '{"branch_nt",  7'b1100011, 0, 0,  1'b0, 3,  0, 1, 1};
        vecs[9]  = '{"jal",        7'b1101111, 0, 0,  1'b0, 3,  1, 2, 1};
        vecs[10] = '{"jalr",       7'b1100111, 0, 0,  1'b0, 3,  1, 2, 1};
        vecs[11] = '{"illegal",    7'b1111111, 0, 0,  1'b0, 0,  0, 1, 0};
        vecs[12] = '{"fetch_last", 7'b0110011, 14, 0, 1'b0, 18, 1, 1, 1};
        vecs[13] = '{"load_last",  7'b0000011, 0, 14, 1'b0, 19, 1, 1, 1};

        for (int i = 0; i < 14; i++) begin
            do_reset();
            run_instr(vecs[i].name, vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].z,
                      cyc, rw, pce, done);
            check_int({vecs[i].name, "_cycles"}, cyc, vecs[i].cyc);
            check_int({vecs[i].name, "_reg_write"}, rw, vecs[i].rw);
            check_int({vecs[i].name, "_pc_en"}, pce, vecs[i].pce);
            check_int({vecs[i].name, "_done"}, done, vecs[i].done);
        end

        // Back-to-back random legal instructions with random wait states.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            run_instr("rand", OPS[$urandom_range(0, 8)], $urandom_range(0, 4),
                      $urandom_range(0, 4), 1'($urandom), cyc, rw, pce, done);
            check_int("rand_done", done, 1);
        end

        // Fetch never ready: 15 wait cycles then ERR, which ignores mem_ready.
        do_reset();
        for (int i = 0; i < 15; i++)
            run_cycle(1'b0, 1'($urandom), 7'($urandom), 4'd1, $sformatf("to_fetch%0d", i), d, r, p);
        for (int i = 0; i < 4; i++)
            run_cycle(1'($urandom), 1'($urandom), 7'($urandom), 4'd13, $sformatf("to_err%0d", i), d, r, p);
        $display("instr timeout_fetch state=%0d bus_err=%0b", state_o, bus_err);

        // Store stalled in MEM_WR timing out after 15 wait cycles.
        do_reset();
        run_cycle(1'b1, 1'b0, 7'b0100011, 4'd1, "tow_fetch", d, r, p);
        run_cycle(1'b0, 1'b0, 7'b0100011, 4'd2, "tow_decode", d, r, p);
        run_cycle(1'b0, 1'b0, 7'b0100011, 4'd5, "tow_addr", d, r, p);
        for (int i = 0; i < 15; i++)
            run_cycle(1'b0, 1'b0, 7'b0100011, 4'd8, $sformatf("tow_wr%0d", i), d, r, p);
        run_cycle(1'b1, 1'b0, 7'b0100011, 4'd13, "tow_err", d, r, p);
        $display("instr timeout_store state=%0d bus_err=%0b", state_o, bus_err);

        // Asynchronous reset in the middle of a stalled store.
        do_reset();
        run_cycle(1'b1, 1'b0, 7'b0100011, 4'd1, "ar_fetch", d, r, p);
        run_cycle(1'b0, 1'b0, 7'b0100011, 4'd2, "ar_decode", d, r, p);
        run_cycle(1'b0, 1'b0, 7'b0100011, 4'd5, "ar_addr", d, r, p);
        run_cycle(1'b0, 1'b0, 7'b0100011, 4'd8, "ar_wr0", d, r, p);
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset_now", obs, '0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1 check("async_reset_held", obs, '0);
        $display("instr async_reset state=%0d", state_o);
        do_reset();
        run_instr("after_reset", 7'b1101111, 0, 0, 1'b0, cyc, rw, pce, done);
        check_int("after_reset_cycles", cyc, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
